regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 97 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter feeding one regfile write port, plus a pending-register scoreboard.
// Grant is combinational; the write reaches the regfile 1 cycle later. Losing requesters hold until req_ready.
module regfile_wb_arbiter #(
  parameter int DATAPATH_WIDTH     = 64,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int NUM_REQ            = 3
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQ-1:0]                       req_valid,
  input  logic [NUM_REQ*REGFILE_ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATAPATH_WIDTH-1:0]        req_data,
  output logic [NUM_REQ-1:0]                       req_ready,
  output logic                                     wr_en,
  output logic [REGFILE_ADDR_WIDTH-1:0]            wr_addr,
  output logic [DATAPATH_WIDTH-1:0]                wr_data,
  input  logic                                     sb_set_valid,
  input  logic [REGFILE_ADDR_WIDTH-1:0]            sb_set_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0]            rs1_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0]            rs2_addr,
  output logic                                     rs1_busy,
  output logic                                     rs2_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int DEPTH = 1 << REGFILE_ADDR_WIDTH;

  logic [PTR_W-1:0]              rr_ptr;
  logic [PTR_W-1:0]              grant_idx;
  logic [PTR_W-1:0]              next_ptr;
  logic [PTR_W-1:0]              cand;
  logic                          grant_any;
  logic [NUM_REQ-1:0]            grant;
  logic [DEPTH-1:0]              busy;
  logic [DEPTH-1:0]              busy_next;
  logic [REGFILE_ADDR_WIDTH-1:0] sel_addr;
  logic [DATAPATH_WIDTH-1:0]     sel_data;
  int                            idx;

  // Scan from rr_ptr upward, wrapping; first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PTR_W'(idx);
      if (!grant_any && req_valid[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
    if (reset) begin
      grant     = '0;
      grant_any = 1'b0;
    end
  end

  assign req_ready = grant;
  assign sel_addr  = req_addr[grant_idx*REGFILE_ADDR_WIDTH +: REGFILE_ADDR_WIDTH];
  assign sel_data  = req_data[grant_idx*DATAPATH_WIDTH +: DATAPATH_WIDTH];
  assign next_ptr  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Clear before set so a same-cycle issue to the register being written back keeps it pending.
  always_comb begin
    busy_next = busy;
    if (grant_any) busy_next[sel_addr] = 1'b0;
    if (sb_set_valid && (sb_set_addr != '0)) busy_next[sb_set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rr_ptr  <= '0;
      busy    <= '0;
    end else begin
      wr_en <= grant_any && (sel_addr != '0);
      if (grant_any) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        rr_ptr  <= next_ptr;
      end
      busy <= busy_next;
    end
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue/array reference model.
module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 64;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              sb_set_valid;
  logic [AW-1:0]     sb_set_addr;
  logic [AW-1:0]     rs1_addr;
  logic [AW-1:0]     rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;

  regfile_wb_arbiter #(.DATAPATH_WIDTH(DW), .REGFILE_ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set_valid(sb_set_valid), .sb_set_addr(sb_set_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: rotating priority start, pending set, last regfile write.
  int          m_ptr;
  bit          m_busy [32];
  bit          m_wr_en;
  bit [AW-1:0] m_wr_addr;
  bit [DW-1:0] m_wr_data;
  int          m_last_g;
  int          grants[$];
  logic [NR-1:0] obs_ready;
  logic          obs_rs1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
  endtask

  // One clock: inputs already applied just after the previous rising edge.
  task automatic step();
    int g;
    logic [NR-1:0] exp_ready;
    bit [AW-1:0] a;
    g = -1;
    if (!reset)
      for (int k = 0; k < NR; k++)
        if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    #2;
    obs_ready = req_ready;
    obs_rs1   = rs1_busy;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1_addr]));
    check("rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2_addr]));
    m_last_g = g;
    if (reset) begin
      model_reset();
    end else begin
      m_wr_en = 1'b0;
      if (g >= 0) begin
        grants.push_back(g);
        a = req_addr[g*AW +: AW];
        m_wr_en   = (a != 0);
        m_wr_addr = a;
        m_wr_data = req_data[g*DW +: DW];
        m_ptr     = (g + 1) % NR;
        m_busy[a] = 1'b0;
      end
      if (sb_set_valid && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("wr_en", 64'(wr_en), 64'(m_wr_en));
    check("wr_addr", 64'(wr_addr), 64'(m_wr_addr));
    check("wr_data", wr_data, m_wr_data);
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_addr = '0; req_data = '0;
    sb_set_valid = 1'b0; sb_set_addr = '0; rs1_addr = '0; rs2_addr = '0;
  endtask

  bit          pend [NR];
  bit [AW-1:0] p_addr [NR];
  bit [DW-1:0] p_data [NR];
  int          waitc [NR];

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    step();   // reset held: outputs and grant forced low

    // All three valid continuously from reset: strict rotation.
    reset = 1'b0;
    grants.delete();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = 1'b1;
        req_addr[i*AW +: AW] = AW'(i + 1);
        req_data[i*DW +: DW] = 64'(c * 16 + i);
      end
      step();
    end
    check("order_len", 64'(grants.size()), 64'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++) check("order", 64'(grants[i]), 64'(i % 3));

    // Single requester, rr_ptr back at 0.
    idle_inputs();
    req_valid = 3'b001; req_addr[0 +: AW] = 5'd5; req_data[0 +: DW] = 64'hDEAD;
    step();
    check("r0_ready", 64'(obs_ready), 64'b001);
    check("r0_wr_en", 64'(wr_en), 64'd1);
    check("r0_wr_addr", 64'(wr_addr), 64'd5);
    check("r0_wr_data", wr_data, 64'hDEAD);

    // Write to x0 is granted but dropped.
    idle_inputs();
    req_valid = 3'b010; req_addr[AW +: AW] = 5'd0; req_data[DW +: DW] = 64'hFF;
    step();
    check("x0_ready", 64'(obs_ready), 64'b010);
    check("x0_wr_en", 64'(wr_en), 64'd0);
    check("x0_wr_data", wr_data, 64'hFF);

    // Scoreboard set / clear / set-wins.
    idle_inputs(); sb_set_valid = 1'b1; sb_set_addr = 5'd7; step();
    idle_inputs(); rs1_addr = 5'd7; step();
    check("sb_set", 64'(obs_rs1), 64'd1);
    req_valid = 3'b001; req_addr[0 +: AW] = 5'd7; req_data[0 +: DW] = 64'h77; step();
    idle_inputs(); rs1_addr = 5'd7; step();
    check("sb_clear", 64'(obs_rs1), 64'd0);
    sb_set_valid = 1'b1; sb_set_addr = 5'd7; step();
    req_valid = 3'b001; req_addr[0 +: AW] = 5'd7; step();
    idle_inputs(); rs1_addr = 5'd7; step();
    check("sb_set_wins", 64'(obs_rs1), 64'd1);

    // Reset with busy[3], req2 pending and rr_ptr=2.
    idle_inputs(); sb_set_valid = 1'b1; sb_set_addr = 5'd3; step();
    idle_inputs(); req_valid = 3'b010; req_addr[AW +: AW] = 5'd9; step();
    idle_inputs(); req_valid = 3'b100; req_addr[2*AW +: AW] = 5'd4; rs1_addr = 5'd3; rs2_addr = 5'd3;
    reset = 1'b1; step();
    check("rst_ready", 64'(obs_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    reset = 1'b0; req_valid = '0; step();
    check("rst_busy", 64'(obs_rs1), 64'd0);
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = 1'b1; req_addr[i*AW +: AW] = AW'(10 + i);
    end
    step();
    check("rst_ptr0", 64'(obs_ready), 64'b001);

    // Randomized traffic with stable-until-ready requesters.
    idle_inputs();
    for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; waitc[i] = 0; end
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]   = 1'b1;
          p_addr[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(0, 31));
          p_data[i] = {$urandom, $urandom};
        end
        req_valid[i] = pend[i];
        req_addr[i*AW +: AW] = p_addr[i];
        req_data[i*DW +: DW] = p_data[i];
      end
      sb_set_valid = ($urandom_range(0, 2) == 0);
      sb_set_addr  = AW'($urandom_range(0, 31));
      rs1_addr     = AW'($urandom_range(0, 31));
      rs2_addr     = AW'($urandom_range(0, 31));
      step();
      for (int i = 0; i < NR; i++) begin
        if (reset) waitc[i] = 0;
        else if (pend[i]) waitc[i]++;
      end
      if (m_last_g >= 0) begin
        check("no_starve", 64'(waitc[m_last_g] <= NR), 64'd1);
        pend[m_last_g]  = 1'b0;
        waitc[m_last_g] = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
